conv_bias_relu_32x32: RTL and testbench
=======================================

# conv_bias_relu_32x32

Per-output-channel bias add and ReLU stage placed directly downstream of `conv_channel_in_adder_32x32`. It consumes the completed channel-summed feature map (IMAGE_SIZE pixels per output channel, channel after channel) and adds the bias of the current output channel using `floating_point_1_add`. It then clamps negative results to zero and forwards the stream to the next layer. Biases are loaded into an internal register file between frames.

## Interface
- DATA_WIDTH, 32, IEEE-754 single-precision word width
- IMAGE_SIZE, 32*32, pixels per output channel
- CHANNEL_NUM_OUT, 256, output channels per frame
- ADD_LATENCY, 11, fixed cycle latency of `floating_point_1_add` (tvalid to tvalid)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset; drives adder `aresetn` directly
- valid_in  input  1  pxl_in qualifier
- pxl_in  input  DATA_WIDTH  channel-summed pixel
- bias_wr_en  input  1  bias register write strobe
- bias_wr_addr  input  $clog2(CHANNEL_NUM_OUT)  bias index
- bias_in  input  DATA_WIDTH  bias value
- pxl_out  output  DATA_WIDTH  biased, rectified pixel; 0 when valid_out=0
- valid_out  output  1  pxl_out qualifier
- busy  output  1  frame in flight (state != IDLE)
- frame_done  output  1  one-cycle pulse with the last valid_out of a frame
- overrun  output  1  sticky error: valid_in seen in DRAIN

## Operation
- Bias file: CHANNEL_NUM_OUT x DATA_WIDTH registers. A write is accepted only in IDLE. Writes in RUN or DRAIN are ignored. Contents are not cleared by reset.
- Input counters: pix_cnt 0..IMAGE_SIZE-1 and ch_cnt 0..CHANNEL_NUM_OUT-1, advanced only on valid_in.
  - pix_cnt wraps to 0 after IMAGE_SIZE-1 and increments ch_cnt.
  - ch_cnt wraps to 0 after CHANNEL_NUM_OUT-1.
- Output counters: opix_cnt and och_cnt have the same structure and advance on adder result valid.
- Stage 1: register pxl_in, valid_in, and bias[ch_cnt], sampled with the same valid_in.
- Stage 2: `floating_point_1_add`, with a_tvalid = b_tvalid = stage-1 valid.
- Stage 3: ReLU and output register. valid_out = adder tvalid delayed one cycle.
- FSM:
  - IDLE: valid_in moves to RUN.
  - RUN: a valid_in at pix_cnt=IMAGE_SIZE-1 and ch_cnt=CHANNEL_NUM_OUT-1 moves to DRAIN.
  - DRAIN: the output with opix_cnt=IMAGE_SIZE-1 and och_cnt=CHANNEL_NUM_OUT-1 asserts frame_done and moves to IDLE.
- valid_in in DRAIN: the pixel is dropped, counters hold, and overrun is set. overrun clears only on reset.
- NaN and infinity propagate per adder behaviour, subject to ReLU on the sign bit.

## Timing
- Latency: valid_in at cycle t gives valid_out at t + 1 + ADD_LATENCY + 1 = t+13 at default.
- Throughput is one pixel per cycle. Gaps in valid_in appear as identical gaps in valid_out.
- No backpressure; the downstream stage must accept every valid_out.
- frame_done is coincident with the final valid_out of a frame, never asserted alone.
- busy rises the cycle after the first valid_in and falls the cycle after frame_done.
- A bias write in IDLE at cycle t is visible to a valid_in at cycle t+1.
- Reset asserted (low):
  - Outputs, counters, pipeline valids, and overrun clear immediately and asynchronously.
  - State returns to IDLE.
  - In-flight pixels are discarded and no partial frame_done is produced.
- Reset values: pxl_out=0, valid_out=0, busy=0, frame_done=0, overrun=0.

## Configuration
- CONV_BIAS_RELU_EN
- Defined: stage 3 outputs 32'h0000_0000 when the adder result sign bit = 1 (including -0.0 and negative NaN); otherwise it outputs the sum.
- Undefined: stage 3 passes the adder result unchanged (bias add only). Latency is unchanged, so a 3-stage pipeline is kept in both builds.

## Test plan
- Reset: hold reset=0 and drive random inputs -> pxl_out=0, valid_out=0, busy=0, frame_done=0, overrun=0.
- Basic bias add: in IDLE write bias[0]=0x3F800000 (1.0); valid_in with pxl_in=0x40000000 (2.0) at cycle t -> pxl_out=0x40400000 (3.0), valid_out=1 at t+13.
- ReLU: bias[1]=0xC0000000 (-2.0); a channel-1 pixel 0x3F800000 -> 0x00000000 with valid_out=1 when CONV_BIAS_RELU_EN is defined, 0xBF800000 when it is not.
- Channel and frame wrap:
  - Stream CHANNEL_NUM_OUT*IMAGE_SIZE pixels with random one-cycle gaps; output k uses bias[k/IMAGE_SIZE].
  - Exactly one frame_done, on the last valid_out.
  - busy falls next cycle, and the next frame uses bias[0] again.
- Bias write lockout: in RUN, write bias[0]=0x41200000 -> ignored, and the next frame still adds the old bias[0]. The same write after busy=0 takes effect.
- Abuse cases:
  - Assert valid_in during DRAIN -> pixel absent from output, overrun=1 and sticky.
  - Assert reset mid-frame -> all valids drop at once; after release the first pixel uses bias[0] and pix_cnt starts at 0.

Source files
------------

// File: rtl/conv_bias_relu_32x32_if.sv
// Pixel stream, bias-load port and status flags of conv_bias_relu_32x32.
// The master side drives pixels and bias writes; the slave is the bias/ReLU stage.
interface conv_bias_relu_32x32_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  bias_wr_en;
  logic [ADDR_WIDTH-1:0] bias_wr_addr;
  logic [DATA_WIDTH-1:0] bias_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  modport master (
    output valid_in, pxl_in, bias_wr_en, bias_wr_addr, bias_in,
    input  pxl_out, valid_out, busy, frame_done, overrun
  );

  modport slave (
    input  valid_in, pxl_in, bias_wr_en, bias_wr_addr, bias_in,
    output pxl_out, valid_out, busy, frame_done, overrun
  );
endinterface

// File: rtl/conv_bias_relu_32x32.sv
// Per-output-channel bias add (fp32, ADD_LATENCY-cycle adder) followed by an optional ReLU.
// Define CONV_BIAS_RELU_EN to clamp sign-bit-set results to zero; otherwise bias add only.
module conv_bias_relu_32x32 #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMAGE_SIZE      = 32 * 32,
  parameter int unsigned CHANNEL_NUM_OUT = 256,
  parameter int unsigned ADD_LATENCY     = 11
) (
  input logic                   clk,
  input logic                   reset,
  conv_bias_relu_32x32_if.slave bus
);
  localparam int unsigned PIX_W = $clog2(IMAGE_SIZE);
  localparam int unsigned CH_W  = $clog2(CHANNEL_NUM_OUT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Single-precision add, round-to-nearest-even; subnormal inputs/outputs flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        sx, sy;
    logic [7:0]  ea, eb, ex, ey, d;
    logic [22:0] fa, fb;
    logic [27:0] mx, my, my_sh, sum;
    logic        sticky, rup, found;
    logic [4:0]  lz;
    logic [23:0] rnd;
    int          e_res;
    logic [31:0] res;
    ea  = a[30:23];
    fa  = a[22:0];
    eb  = b[30:23];
    fb  = b[22:0];
    res = '0;
    if (ea == 8'hff && fa != 23'h0) begin
      res = {a[31], 8'hff, 1'b1, a[21:0]};
    end else if (eb == 8'hff && fb != 23'h0) begin
      res = {b[31], 8'hff, 1'b1, b[21:0]};
    end else if (ea == 8'hff && eb == 8'hff) begin
      res = (a[31] != b[31]) ? 32'h7fc0_0000 : a;
    end else if (ea == 8'hff) begin
      res = a;
    end else if (eb == 8'hff) begin
      res = b;
    end else if (ea == 8'h00 && eb == 8'h00) begin
      res = {a[31] & b[31], 31'h0};
    end else if (ea == 8'h00) begin
      res = b;
    end else if (eb == 8'h00) begin
      res = a;
    end else begin
      // Larger magnitude goes to x so the mantissa difference never goes negative.
      if ({ea, fa} >= {eb, fb}) begin
        sx = a[31]; ex = ea; mx = {2'b01, fa, 3'b000};
        sy = b[31]; ey = eb; my = {2'b01, fb, 3'b000};
      end else begin
        sx = b[31]; ex = eb; mx = {2'b01, fb, 3'b000};
        sy = a[31]; ey = ea; my = {2'b01, fa, 3'b000};
      end
      d         = ex - ey;
      my_sh     = my >> d;
      sticky    = ((my_sh << d) != my);
      my_sh[0]  = my_sh[0] | sticky;
      e_res     = int'(ex);
      lz        = '0;
      found     = 1'b0;
      if (sx == sy) begin
        sum = mx + my_sh;
        if (sum[27]) begin
          sum = {1'b0, sum[27:1]} | {27'b0, sum[0]};
          e_res++;
        end
      end else begin
        sum = mx - my_sh;
        for (int i = 26; i >= 0; i--) begin
          if (!found && sum[i]) begin
            lz    = 5'(26 - i);
            found = 1'b1;
          end
        end
        sum   = sum << lz;
        e_res = e_res - int'(lz);
      end
      if (sum == 28'h0) begin
        res = '0;
      end else begin
        rup = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd = {1'b0, sum[25:3]} + {23'b0, rup};
        if (rnd[23]) begin
          e_res++;
        end
        if (e_res >= 255) begin
          res = {sx, 8'hff, 23'h0};
        end else if (e_res <= 0) begin
          res = {sx, 31'h0};
        end else begin
          res = {sx, e_res[7:0], rnd[22:0]};
        end
      end
    end
    return res;
  endfunction

  state_e                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_bias [CHANNEL_NUM_OUT];
  logic [PIX_W-1:0]      r_pix_cnt, r_opix_cnt;
  logic [CH_W-1:0]       r_ch_cnt, r_och_cnt;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_pxl, r_s1_bias;
  logic [ADD_LATENCY-1:0] r_add_valid;
  logic [DATA_WIDTH-1:0] r_add_data [ADD_LATENCY];
  logic                  r_valid_out, r_frame_done, r_overrun;
  logic [DATA_WIDTH-1:0] r_pxl_out;

  logic                  w_accept, w_bias_we, w_pix_last, w_ch_last, w_in_last;
  logic                  w_opix_last, w_och_last, w_res_valid;
  logic [DATA_WIDTH-1:0] w_sum, w_res, w_relu;

  assign w_accept    = bus.valid_in && (r_state != StDrain);
  assign w_bias_we   = bus.bias_wr_en && (r_state == StIdle);
  assign w_pix_last  = (r_pix_cnt == PIX_W'(IMAGE_SIZE - 1));
  assign w_ch_last   = (r_ch_cnt == CH_W'(CHANNEL_NUM_OUT - 1));
  assign w_in_last   = w_pix_last && w_ch_last;
  assign w_opix_last = (r_opix_cnt == PIX_W'(IMAGE_SIZE - 1));
  assign w_och_last  = (r_och_cnt == CH_W'(CHANNEL_NUM_OUT - 1));
  assign w_res_valid = r_add_valid[ADD_LATENCY-1];
  assign w_res       = r_add_data[ADD_LATENCY-1];

  // Bias file holds its contents across reset.
  always_ff @(posedge clk) begin
    if (w_bias_we) begin
      r_bias[bus.bias_wr_addr] <= bus.bias_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.valid_in) w_state_next = w_in_last ? StDrain : StRun;
      StRun:   if (bus.valid_in && w_in_last) w_state_next = StDrain;
      StDrain: if (r_frame_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_cnt <= '0;
      r_ch_cnt  <= '0;
    end else if (w_accept) begin
      if (w_pix_last) begin
        r_pix_cnt <= '0;
        r_ch_cnt  <= w_ch_last ? '0 : r_ch_cnt + 1'b1;
      end else begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opix_cnt <= '0;
      r_och_cnt  <= '0;
    end else if (w_res_valid) begin
      if (w_opix_last) begin
        r_opix_cnt <= '0;
        r_och_cnt  <= w_och_last ? '0 : r_och_cnt + 1'b1;
      end else begin
        r_opix_cnt <= r_opix_cnt + 1'b1;
      end
    end
  end

  // Stage 1: pixel and its channel bias captured on the same accepted valid_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_pxl   <= '0;
      r_s1_bias  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pxl  <= bus.pxl_in;
        r_s1_bias <= r_bias[r_ch_cnt];
      end
    end
  end

  // Stage 2: adder with a fixed ADD_LATENCY tvalid-to-tvalid delay.
  always_comb begin
    w_sum = fp_add(r_s1_pxl, r_s1_bias);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_add_valid <= '0;
      for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
        r_add_data[i] <= '0;
      end
    end else begin
      r_add_valid[0] <= r_s1_valid;
      r_add_data[0]  <= w_sum;
      for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
        r_add_valid[i] <= r_add_valid[i-1];
        r_add_data[i]  <= r_add_data[i-1];
      end
    end
  end

`ifdef CONV_BIAS_RELU_EN
  assign w_relu = w_res[DATA_WIDTH-1] ? '0 : w_res;
`else
  assign w_relu = w_res;
`endif

  // Stage 3: output register; frame_done rides along with the final pixel of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_out  <= 1'b0;
      r_pxl_out    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_res_valid;
      r_pxl_out    <= w_res_valid ? w_relu : '0;
      r_frame_done <= w_res_valid && w_opix_last && w_och_last && (r_state == StDrain);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (bus.valid_in && (r_state == StDrain)) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.pxl_out    = r_pxl_out;
  assign bus.valid_out  = r_valid_out;
  assign bus.busy       = (r_state != StIdle);
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_conv_bias_relu_32x32.sv
// Bench for conv_bias_relu_32x32 on a reduced 4-pixel x 4-channel frame.
// Expected sums are hand-computed fp32 constants; ReLU column chosen by CONV_BIAS_RELU_EN.
module tb_conv_bias_relu_32x32;
  typedef struct {
    logic [31:0] pxl;
    logic [31:0] exp_add;
    logic [31:0] exp_relu;
  } vec_t;

`ifdef CONV_BIAS_RELU_EN
  localparam bit ReluEn = 1'b1;
`else
  localparam bit ReluEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lone_fd = 0;
  int   idle_nz = 0;

  logic [31:0] obs_pxl[$];
  int          obs_cyc[$];
  bit          obs_fd[$];
  int          in_cyc[$];
  vec_t        tbl[16];

  conv_bias_relu_32x32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus_if ();

  conv_bias_relu_32x32 #(
    .DATA_WIDTH     (32),
    .IMAGE_SIZE     (4),
    .CHANNEL_NUM_OUT(4),
    .ADD_LATENCY    (11)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.valid_out) begin
      obs_pxl.push_back(bus_if.pxl_out);
      obs_cyc.push_back(cyc);
      obs_fd.push_back(bus_if.frame_done);
    end else begin
      if (bus_if.frame_done) lone_fd <= lone_fd + 1;
      if (bus_if.pxl_out != 32'h0) idle_nz <= idle_nz + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expected(input int i);
    return ReluEn ? tbl[i].exp_relu : tbl[i].exp_add;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus_if.valid_in   = 1'b0;
    bus_if.pxl_in     = $urandom();
    bus_if.bias_wr_en = 1'b0;
  endtask

  task automatic write_bias(input logic [1:0] addr, input logic [31:0] val);
    @(posedge clk); #1;
    bus_if.valid_in     = 1'b0;
    bus_if.bias_wr_en   = 1'b1;
    bus_if.bias_wr_addr = addr;
    bus_if.bias_in      = val;
  endtask

  task automatic clear_obs();
    obs_pxl.delete();
    obs_cyc.delete();
    obs_fd.delete();
    in_cyc.delete();
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit lock_wr, input bit poke);
    bit found;
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 1 && $urandom_range(0, 1) == 1) idle_cycle();
      @(posedge clk); #1;
      bus_if.valid_in     = 1'b1;
      bus_if.pxl_in       = tbl[i].pxl;
      bus_if.bias_wr_en   = lock_wr && (i == 8);
      bus_if.bias_wr_addr = 2'd0;
      bus_if.bias_in      = 32'h4120_0000;
      in_cyc.push_back(cyc);
      if (i == 0) begin
        @(negedge clk);
        check({tag, " busy on first valid_in"}, 32'(bus_if.busy), 32'd0);
      end
      if (i == 1) begin
        @(negedge clk);
        check({tag, " busy after first valid_in"}, 32'(bus_if.busy), 32'd1);
      end
    end
    if (poke) begin
      @(negedge clk);
      check({tag, " overrun before drain poke"}, 32'(bus_if.overrun), 32'd0);
      repeat (2) begin
        @(posedge clk); #1;
        bus_if.valid_in   = 1'b1;
        bus_if.pxl_in     = 32'h4200_0000;
        bus_if.bias_wr_en = 1'b0;
      end
    end
    idle_cycle();
    if (poke) begin
      @(negedge clk);
      check({tag, " overrun after drain poke"}, 32'(bus_if.overrun), 32'd1);
    end
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (bus_if.frame_done) found = 1'b1;
    end
    check({tag, " frame_done seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, " busy with frame_done"}, 32'(bus_if.busy), 32'd1);
      @(negedge clk);
      check({tag, " busy after frame_done"}, 32'(bus_if.busy), 32'd0);
    end
    repeat (3) @(negedge clk);
    check({tag, " output count"}, 32'(obs_pxl.size()), 32'd16);
    for (int i = 0; i < 16 && i < obs_pxl.size(); i++) begin
      check($sformatf("%s pxl[%0d]", tag, i), obs_pxl[i], expected(i));
      check($sformatf("%s latency[%0d]", tag, i), 32'(obs_cyc[i] - in_cyc[i]), 32'd13);
      check($sformatf("%s frame_done[%0d]", tag, i), 32'(obs_fd[i]), 32'(i == 15));
    end
  endtask

  initial begin
    // ch0 bias 1.0, ch1 bias -2.0, ch2 bias 0.5, ch3 bias 1024.0
    tbl[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h4040_0000};  //  2 + 1
    tbl[1]  = '{32'hC040_0000, 32'hC000_0000, 32'h0000_0000};  // -3 + 1
    tbl[2]  = '{32'hBF80_0000, 32'h0000_0000, 32'h0000_0000};  // -1 + 1
    tbl[3]  = '{32'h3F00_0000, 32'h3FC0_0000, 32'h3FC0_0000};  // 0.5 + 1
    tbl[4]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};  //  1 - 2
    tbl[5]  = '{32'h40A0_0000, 32'h4040_0000, 32'h4040_0000};  //  5 - 2
    tbl[6]  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000};  // +inf
    tbl[7]  = '{32'hFF80_0000, 32'hFF80_0000, 32'h0000_0000};  // -inf
    tbl[8]  = '{32'h3E80_0000, 32'h3F40_0000, 32'h3F40_0000};  // 0.25 + 0.5
    tbl[9]  = '{32'h0000_0000, 32'h3F00_0000, 32'h3F00_0000};  // 0 + 0.5
    tbl[10] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};  // qNaN
    tbl[11] = '{32'hBF40_0000, 32'hBE80_0000, 32'h0000_0000};  // -0.75 + 0.5
    tbl[12] = '{32'h3F80_0000, 32'h4480_2000, 32'h4480_2000};  // 1 + 1024
    tbl[13] = '{32'hC480_0000, 32'h0000_0000, 32'h0000_0000};  // -1024 + 1024
    tbl[14] = '{32'h3080_0000, 32'h4480_0000, 32'h4480_0000};  // 2^-30 + 1024 rounds away
    tbl[15] = '{32'hC500_0000, 32'hC480_0000, 32'h0000_0000};  // -2048 + 1024

    bus_if.valid_in     = 1'b0;
    bus_if.pxl_in       = '0;
    bus_if.bias_wr_en   = 1'b0;
    bus_if.bias_wr_addr = '0;
    bus_if.bias_in      = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Random activity while held in reset.
    repeat (6) begin
      @(posedge clk); #1;
      bus_if.valid_in     = 1'($urandom_range(0, 1));
      bus_if.pxl_in       = $urandom();
      bus_if.bias_wr_en   = 1'($urandom_range(0, 1));
      bus_if.bias_wr_addr = 2'($urandom_range(0, 3));
      bus_if.bias_in      = $urandom();
    end
    @(negedge clk);
    check("reset pxl_out", bus_if.pxl_out, 32'h0);
    check("reset valid_out", 32'(bus_if.valid_out), 32'd0);
    check("reset busy", 32'(bus_if.busy), 32'd0);
    check("reset frame_done", 32'(bus_if.frame_done), 32'd0);
    check("reset overrun", 32'(bus_if.overrun), 32'd0);
    bus_if.valid_in   = 1'b0;
    bus_if.bias_wr_en = 1'b0;
    rst_n = 1'b1;

    write_bias(2'd0, 32'h3F80_0000);
    write_bias(2'd1, 32'hC000_0000);
    write_bias(2'd2, 32'h3F00_0000);
    write_bias(2'd3, 32'h4480_0000);
    idle_cycle();

    // Frame 1: random gaps, plus a bias[0] write attempted mid-frame.
    run_frame("f1", 1'b1, 1'b1, 1'b0);
    // Frame 2: back-to-back; bias[0] must still be 1.0; pixels pushed during drain.
    run_frame("f2", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun sticky after frame", 32'(bus_if.overrun), 32'd1);

    // Bias write in IDLE is seen by a valid_in on the very next cycle.
    clear_obs();
    write_bias(2'd0, 32'h4120_0000);
    @(posedge clk); #1;
    bus_if.bias_wr_en = 1'b0;
    bus_if.valid_in   = 1'b1;
    bus_if.pxl_in     = 32'h4000_0000;
    @(posedge clk); #1;
    bus_if.pxl_in     = 32'h3F80_0000;
    idle_cycle();
    repeat (20) @(negedge clk);
    check("new bias count", 32'(obs_pxl.size()), 32'd2);
    if (obs_pxl.size() >= 2) begin
      check("new bias 2+10", obs_pxl[0], 32'h4140_0000);
      check("new bias 1+10", obs_pxl[1], 32'h4130_0000);
    end

    // Reset mid-frame with pixels in flight.
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_if.valid_in = 1'b1;
      bus_if.pxl_in   = 32'h3F80_0000;
    end
    repeat (4) idle_cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid reset valid_out", 32'(bus_if.valid_out), 32'd0);
    check("mid reset pxl_out", bus_if.pxl_out, 32'h0);
    check("mid reset busy", 32'(bus_if.busy), 32'd0);
    check("mid reset overrun", 32'(bus_if.overrun), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("in-flight discarded", 32'(obs_pxl.size()), 32'd0);

    // After reset: four ch0 pixels (bias[0]=10.0 kept), then the first ch1 pixel.
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus_if.valid_in = 1'b1;
      bus_if.pxl_in   = 32'h3F80_0000;
    end
    idle_cycle();
    repeat (20) @(negedge clk);
    check("post reset count", 32'(obs_pxl.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_pxl.size(); i++) begin
      check($sformatf("post reset pxl[%0d]", i), obs_pxl[i],
            (i < 4) ? 32'h4130_0000 : (ReluEn ? 32'h0000_0000 : 32'hBF80_0000));
    end
    check("post reset busy", 32'(bus_if.busy), 32'd1);

    check("frame_done without valid_out", 32'(lone_fd), 32'd0);
    check("pxl_out nonzero while idle", 32'(idle_nz), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
